// File: rtl/tmds_decoder.sv
// ---------------------------------------------------------------------------
// tmds_decoder
//
// Receive-side TMDS channel decoder with symbol word alignment.
// Each pixel_clk delivers one deserialized 10-bit symbol. The symbol is
// classified as a control token or a video data word, then decoded into the
// pixel byte, the two control bits and the active-video flag.
//
// A word-alignment FSM watches the control tokens of the blanking periods.
// While it sees none, it requests one-bit boundary shifts from the
// deserializer. A long enough run of tokens declares lock, and a long token
// drought while locked drops it again.
//
// Ports
//   pixel_clk     symbol clock, one symbol per rising edge
//   n_rst         asynchronous active-low reset
//   data_in       deserialized TMDS symbol, bit 0 transmitted first
//   data_out      decoded pixel byte (held through control periods)
//   d_0, d_1      decoded control bits (held through video periods)
//   active_video  1 = data_out is a video word, 0 = control period
//   bitslip       one-cycle request for a one-bit boundary shift
//   locked        symbol alignment achieved
//
// Latency: 2 cycles from data_in to data_out / d_0 / d_1 / active_video.
// ---------------------------------------------------------------------------
module tmds_decoder #(
  parameter int unsigned CTL_RUN    = 8,
  parameter int unsigned SEARCH_WIN = 1024,
  parameter int unsigned SLIP_WAIT  = 4,
  parameter int unsigned LOSS_WIN   = 4096
) (
  input  logic       pixel_clk,
  input  logic       n_rst,
  input  logic [9:0] data_in,
  output logic [7:0] data_out,
  output logic       d_0,
  output logic       d_1,
  output logic       active_video,
  output logic       bitslip,
  output logic       locked
);

  // The gap counter serves both SEARCH and LOCKED, so it is sized for the
  // larger of the two windows.
  localparam int unsigned GAP_LIM = (SEARCH_WIN > LOSS_WIN) ? SEARCH_WIN : LOSS_WIN;
  localparam int unsigned RUN_W   = $clog2(CTL_RUN) + 1;
  localparam int unsigned GAP_W   = $clog2(GAP_LIM) + 1;
  localparam int unsigned SLIP_W  = $clog2(SLIP_WAIT) + 1;

  localparam logic [RUN_W-1:0]  RUN_LIM    = RUN_W'(CTL_RUN);
  localparam logic [GAP_W-1:0]  SEARCH_LIM = GAP_W'(SEARCH_WIN);
  localparam logic [GAP_W-1:0]  LOSS_LIM   = GAP_W'(LOSS_WIN);
  localparam logic [SLIP_W-1:0] SLIP_LAST  = SLIP_W'(SLIP_WAIT - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_LOCKED
  } state_t;

  // -------------------------------------------------------------------------
  // Stage 1: capture symbol and its classification
  // -------------------------------------------------------------------------
  logic       in_ctl;
  logic [9:0] s1_word;
  logic       s1_ctl;
  logic       s1_valid;

  always_comb begin
    in_ctl = (data_in == TOK_00) || (data_in == TOK_01) ||
             (data_in == TOK_10) || (data_in == TOK_11);
  end

  // s1_valid keeps the reset contents of stage 1 from being treated as a
  // received symbol by the decoder or the alignment counters.
  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_word  <= '0;
      s1_ctl   <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_word  <= data_in;
      s1_ctl   <= in_ctl;
      s1_valid <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: decode
  // -------------------------------------------------------------------------
  logic [1:0] s1_code;
  logic [7:0] q;
  logic [7:0] dec;

  always_comb begin
    case (s1_word)
      TOK_01:  s1_code = 2'b01;
      TOK_10:  s1_code = 2'b10;
      TOK_11:  s1_code = 2'b11;
      default: s1_code = 2'b00;
    endcase
  end

  // Undo the optional inversion (bit 9), then undo the XOR/XNOR chain.
  // Bit 8 selects XOR (1) or XNOR (0), so XNOR is XOR with all-ones.
  always_comb begin
    q   = s1_word[9] ? ~s1_word[7:0] : s1_word[7:0];
    dec = {(q[7:1] ^ q[6:0]) ^ {7{~s1_word[8]}}, q[0]};
  end

  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      data_out     <= '0;
      d_0          <= 1'b0;
      d_1          <= 1'b0;
      active_video <= 1'b0;
    end else if (s1_valid) begin
      if (s1_ctl) begin
        active_video <= 1'b0;
        d_1          <= s1_code[1];
        d_0          <= s1_code[0];
      end else begin
        active_video <= 1'b1;
        data_out     <= dec;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Word-alignment FSM (runs on the stage-1 classification)
  // -------------------------------------------------------------------------
  state_t            state;
  logic [RUN_W-1:0]  ctl_run;
  logic [GAP_W-1:0]  gap;
  logic [SLIP_W-1:0] slip_cnt;
  logic [RUN_W-1:0]  run_inc;
  logic [GAP_W-1:0]  gap_inc;

  // Saturating increments: the counters never wrap.
  always_comb begin
    run_inc = (ctl_run == '1) ? ctl_run : ctl_run + RUN_W'(1);
    gap_inc = (gap == '1) ? gap : gap + GAP_W'(1);
  end

  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_SEARCH;
      ctl_run  <= '0;
      gap      <= '0;
      slip_cnt <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (s1_valid) begin
            // A token clears gap and a data word clears ctl_run, so the lock
            // and slip conditions are tested on exclusive branches; lock is
            // still checked first so it always takes priority.
            if (s1_ctl) begin
              gap <= '0;
              if (run_inc == RUN_LIM) begin
                state   <= ST_LOCKED;
                locked  <= 1'b1;
                ctl_run <= '0;
              end else begin
                ctl_run <= run_inc;
              end
            end else begin
              ctl_run <= '0;
              if (gap_inc == SEARCH_LIM) begin
                state    <= ST_SLIP;
                bitslip  <= 1'b1;
                gap      <= '0;
                slip_cnt <= '0;
              end else begin
                gap <= gap_inc;
              end
            end
          end
        end

        ST_SLIP: begin
          // Symbols arriving while the deserializer settles are ignored.
          if (slip_cnt == SLIP_LAST) begin
            state    <= ST_SEARCH;
            slip_cnt <= '0;
            ctl_run  <= '0;
            gap      <= '0;
          end else begin
            slip_cnt <= slip_cnt + SLIP_W'(1);
          end
        end

        ST_LOCKED: begin
          if (s1_ctl) begin
            gap <= '0;
          end else if (gap_inc == LOSS_LIM) begin
            state   <= ST_SEARCH;
            locked  <= 1'b0;
            gap     <= '0;
            ctl_run <= '0;
          end else begin
            gap <= gap_inc;
          end
        end

        default: begin
          state   <= ST_SEARCH;
          locked  <= 1'b0;
          ctl_run <= '0;
          gap     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;

  logic       pixel_clk = 1'b0;
  logic       n_rst     = 1'b0;
  logic [9:0] data_in   = '0;
  logic [7:0] data_out;
  logic       d_0;
  logic       d_1;
  logic       active_video;
  logic       bitslip;
  logic       locked;

  tmds_decoder #(
    .CTL_RUN   (8),
    .SEARCH_WIN(1024),
    .SLIP_WAIT (4),
    .LOSS_WIN  (4096)
  ) dut (
    .pixel_clk   (pixel_clk),
    .n_rst       (n_rst),
    .data_in     (data_in),
    .data_out    (data_out),
    .d_0         (d_0),
    .d_1         (d_1),
    .active_video(active_video),
    .bitslip     (bitslip),
    .locked      (locked)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [7:0] dout;
    logic       d1;
    logic       d0;
    logic       av;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] m_dout      = '0;
  logic [1:0] m_d         = '0;
  logic [9:0] toks[4]     = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  // Reference decode written bit by bit from the TMDS decode rule.
  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] qq;
    logic [7:0] r;
    qq = s[9] ? ~s[7:0] : s[7:0];
    r[0] = qq[0];
    for (int i = 1; i < 8; i++)
      r[i] = s[8] ? (qq[i] ^ qq[i-1]) : ~(qq[i] ^ qq[i-1]);
    return r;
  endfunction

  function automatic int tok_code(input logic [9:0] s);
    case (s)
      10'b1101010100: return 0;
      10'b0010101011: return 1;
      10'b0101010100: return 2;
      10'b1010101011: return 3;
      default:        return -1;
    endcase
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    if (tok_code(w) >= 0) w = 10'h100;
    return w;
  endfunction

  // Drive one symbol, push its expected decoded outputs, advance one edge.
  task automatic step(input logic [9:0] sym);
    int c;
    data_in = sym;
    c = tok_code(sym);
    if (c >= 0) begin
      m_d = c[1:0];
      sb.push_back('{dout: m_dout, d1: m_d[1], d0: m_d[0], av: 1'b0});
    end else begin
      m_dout = ref_decode(sym);
      sb.push_back('{dout: m_dout, d1: m_d[1], d0: m_d[0], av: 1'b1});
    end
    @(posedge pixel_clk);
    #2;
  endtask

  task automatic enter_reset();
    n_rst = 1'b0;
    sb.delete();
    m_dout = '0;
    m_d    = '0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge pixel_clk);
    #2;
    n_rst = 1'b1;
  endtask

  // Scoreboard: a symbol reaches the outputs two edges after being driven.
  always @(posedge pixel_clk) begin
    #1;
    if (n_rst && sb.size() >= 2) begin
      mon_e = sb.pop_front();
      vectors++;
      if ({data_out, d_1, d_0, active_video} !== mon_e) begin
        miscompares++;
        $display("FAIL decode: got dout=%h d1=%b d0=%b av=%b expected dout=%h d1=%b d0=%b av=%b",
                 data_out, d_1, d_0, active_video, mon_e.dout, mon_e.d1, mon_e.d0, mon_e.av);
      end
    end
  end

  task automatic test_reset();
    enter_reset();
    #1;
    vectors++;
    if ({data_out, d_0, d_1, active_video, bitslip, locked} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 0",
               {data_out, d_0, d_1, active_video, bitslip, locked});
    end
    release_reset();
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 9; i++) begin
      step(10'h354);
      vectors++;
      if (locked !== (i >= 9) || bitslip !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_run[%0d]: got locked=%b bitslip=%b expected locked=%b bitslip=0",
                 i, locked, bitslip, (i >= 9));
      end
    end
  endtask

  task automatic test_data();
    step(10'h100);
    step(10'h2FF);
    vectors++;
    if (data_out !== 8'h00 || active_video !== 1'b1) begin
      miscompares++;
      $display("FAIL data_100: got dout=%h av=%b expected dout=00 av=1", data_out, active_video);
    end
    step(10'h354);
    vectors++;
    if (data_out !== 8'hFE || active_video !== 1'b1 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL data_2ff: got dout=%h av=%b locked=%b expected dout=fe av=1 locked=1",
               data_out, active_video, locked);
    end
  endtask

  task automatic test_ctl_tokens();
    logic [1:0] want[3];
    want[0] = 2'b01;
    want[1] = 2'b10;
    want[2] = 2'b11;
    step(10'h0AB);
    for (int i = 0; i < 3; i++) begin
      step(i == 0 ? 10'h154 : (i == 1 ? 10'h2AB : 10'h354));
      vectors++;
      if ({d_1, d_0} !== want[i] || active_video !== 1'b0 || data_out !== 8'hFE) begin
        miscompares++;
        $display("FAIL ctl_token[%0d]: got d=%b av=%b dout=%h expected d=%b av=0 dout=fe",
                 i, {d_1, d_0}, active_video, data_out, want[i]);
      end
    end
  endtask

  task automatic test_mixed();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) step(toks[$urandom_range(0, 3)]);
      else step(rand_data());
      vectors++;
      if (locked !== 1'b1 || bitslip !== 1'b0) begin
        miscompares++;
        $display("FAIL mixed_lock[%0d]: got locked=%b bitslip=%b expected locked=1 bitslip=0",
                 i, locked, bitslip);
      end
    end
  endtask

  task automatic test_loss();
    step(10'h354);
    for (int j = 1; j <= 4097; j++) begin
      step(rand_data());
      vectors++;
      if (locked !== (j < 4097) || bitslip !== 1'b0) begin
        miscompares++;
        $display("FAIL loss[%0d]: got locked=%b bitslip=%b expected locked=%b bitslip=0",
                 j, locked, bitslip, (j < 4097));
      end
    end
    for (int k = 1; k <= 9; k++) begin
      step(toks[k % 4]);
      vectors++;
      if (locked !== (k >= 9) || bitslip !== 1'b0) begin
        miscompares++;
        $display("FAIL relock[%0d]: got locked=%b bitslip=%b expected locked=%b bitslip=0",
                 k, locked, bitslip, (k >= 9));
      end
    end
  endtask

  task automatic test_bitslip();
    logic want;
    enter_reset();
    release_reset();
    for (int n = 1; n <= 2060; n++) begin
      step(10'h100);
      want = (n == 1025) || (n == 2053);
      vectors++;
      if (bitslip !== want || locked !== 1'b0) begin
        miscompares++;
        $display("FAIL bitslip[%0d]: got bitslip=%b locked=%b expected bitslip=%b locked=0",
                 n, bitslip, locked, want);
      end
    end
  endtask

  task automatic test_reset_midrun();
    enter_reset();
    release_reset();
    step(10'h2FF);
    for (int i = 0; i < 6; i++) step(10'h2AB);
    vectors++;
    if (data_out !== 8'hFE || {d_1, d_0} !== 2'b11 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset: got dout=%h d=%b locked=%b expected dout=fe d=11 locked=0",
               data_out, {d_1, d_0}, locked);
    end
    #1;
    enter_reset();
    #1;
    vectors++;
    if ({data_out, d_0, d_1, active_video, bitslip, locked} !== 13'h0) begin
      miscompares++;
      $display("FAIL midrun_reset: got %h expected 0",
               {data_out, d_0, d_1, active_video, bitslip, locked});
    end
    release_reset();
    for (int k = 1; k <= 9; k++) begin
      step(10'h2AB);
      vectors++;
      if (locked !== (k >= 9)) begin
        miscompares++;
        $display("FAIL fresh_lock[%0d]: got locked=%b expected %b", k, locked, (k >= 9));
      end
    end
    #1;
    enter_reset();
    #1;
    vectors++;
    if (locked !== 1'b0 || {d_1, d_0} !== 2'b00) begin
      miscompares++;
      $display("FAIL locked_reset: got locked=%b d=%b expected locked=0 d=00", locked, {d_1, d_0});
    end
    release_reset();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_ctl_tokens();
    test_mixed();
    test_loss();
    test_bitslip();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
